instr_fetch_buffer: RTL

- Fetch stage immediately upstream of the instruction decode stage.
- Owns the program counter and issues word-aligned requests to instruction memory.
- Holds returned instructions in a 2-entry in-order buffer and presents one instruction per cycle to decode, with `if_opcode` driving the decoder's opcode input.
- Branch/jump redirects flush the buffer and discard in-flight responses. Decode back-pressure (load stalls included) holds the head instruction stable.

---
 rtl/instr_fetch_buffer.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory and
// feeds decode from a 2-entry in-order buffer, with redirect flush and stale-response drop.
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  localparam logic [2:0] CREDIT = 3'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  pend_q, pend_d;
  // Wider than the 0..2 nominal range: back-to-back redirects under long latency can stack.
  logic [2:0]  drop_q, drop_d;
  logic        rptr_q, rptr_d, wptr_q, wptr_d;
  logic        iw_q, iw_d, ir_q, ir_d;
  logic [31:0] bpc_q   [2];
  logic [31:0] binstr_q[2];
  logic [31:0] ipc_q   [2];

  logic       deq, issue, enq, rsp_drop;
  logic [2:0] occ;

  always_comb begin
    deq      = if_valid & id_ready;
    occ      = {1'b0, pend_q} + {1'b0, cnt_q} - {2'b00, deq};
    issue    = rst & !redirect_valid & (occ < CREDIT);
    rsp_drop = imem_valid & (drop_q != 3'd0);
    // A response with nothing live outstanding (e.g. left over from before reset) is ignored.
    enq      = imem_valid & (drop_q == 3'd0) & (pend_q != 2'd0) & !redirect_valid;

    pc_d   = pc_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    drop_d = drop_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    iw_d   = iw_q;
    ir_d   = ir_q;

    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      cnt_d  = 2'd0;
      pend_d = 2'd0;
      rptr_d = 1'b0;
      wptr_d = 1'b0;
      iw_d   = 1'b0;
      ir_d   = 1'b0;
      drop_d = drop_q + {1'b0, pend_q}
             - {2'b00, imem_valid & ((drop_q != 3'd0) | (pend_q != 2'd0))};
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      pend_d = pend_q + {1'b0, issue} - {1'b0, enq};
      cnt_d  = cnt_q + {1'b0, enq} - {1'b0, deq};
      drop_d = drop_q - {2'b00, rsp_drop};
      rptr_d = rptr_q ^ deq;
      wptr_d = wptr_q ^ enq;
      iw_d   = iw_q ^ issue;
      ir_d   = ir_q ^ enq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= 2'd0;
      pend_q <= 2'd0;
      drop_q <= 3'd0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      iw_q   <= 1'b0;
      ir_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        bpc_q[i]    <= 32'd0;
        binstr_q[i] <= 32'd0;
        ipc_q[i]    <= 32'd0;
      end
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      iw_q   <= iw_d;
      ir_q   <= ir_d;
      if (issue) ipc_q[iw_q] <= pc_q;
      if (enq) begin
        bpc_q[wptr_q]    <= ipc_q[ir_q];
        binstr_q[wptr_q] <= imem_rdata;
      end
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign if_valid  = (cnt_q != 2'd0);
  assign if_pc     = bpc_q[rptr_q];
  assign if_instr  = binstr_q[rptr_q];
  assign if_opcode = binstr_q[rptr_q][6:0];

endmodule
